// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes active-low push buttons, filters bounce with a
// per-key stability counter and emits a clean level plus press/release strobes.
module key_debouncer #(
  parameter int WIDTH = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, stable, accept, next_stable;
  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    logic [CW-1:0] count;
    assign accept[i] = (sync2[i] != stable[i]) && (count == LAST);
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) count <= '0;
      else count <= (sync2[i] == stable[i] || accept[i]) ? '0 : count + 1'b1;
  end
  assign next_stable = (stable & ~accept) | (sync2 & accept);
  // sync1 may be metastable; only sync2 ever reads it
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync1         <= '1;
      sync2         <= '1;
      stable        <= '1;
      pressed       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      sync1         <= key;
      sync2         <= sync1;
      stable        <= next_stable;
      pressed       <= ~next_stable;
      press_pulse   <= accept & ~sync2;
      release_pulse <= accept & sync2;
    end
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scoreboard bench; expected strobes are queued with the edge
// they must appear on and compared every cycle on the falling clock edge.
module tb_key_debouncer;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] key;
  logic [1:0] pressed, press_pulse, release_pulse;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_pr = 2'b00;
  logic [5:0] e;

  typedef struct {
    int         at;
    logic [1:0] pp;
    logic [1:0] rp;
  } ev_t;
  ev_t sb[$];

  key_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .key(key),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void push(int dly, logic [1:0] pp, logic [1:0] rp);
    ev_t ev;
    ev.at = cyc + dly;
    ev.pp = pp;
    ev.rp = rp;
    sb.push_back(ev);
  endfunction

  function automatic logic [5:0] pop_exp();
    logic [1:0] p = 2'b00;
    logic [1:0] r = 2'b00;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      p |= sb[0].pp;
      r |= sb[0].rp;
      void'(sb.pop_front());
    end
    exp_pr = (exp_pr | p) & ~r;
    return {p, r, exp_pr};
  endfunction

  function automatic void do_reset();
    reset_n = 1'b0;
    exp_pr = 2'b00;
    sb.delete();
  endfunction

  task automatic test_reset();
    do_reset();
    key = 2'b11;
    repeat (3) begin
      @(negedge clock);
      n_cmp++;
      if ({press_pulse, release_pulse, pressed} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got pp=%b rp=%b pr=%b need 000000", cyc, press_pulse, release_pulse, pressed);
      end
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clock);
      e = pop_exp();
      n_cmp++;
      if ({press_pulse, release_pulse, pressed} !== e) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got %b_%b_%b need %b_%b_%b", cyc, press_pulse, release_pulse, pressed, e[5:4], e[3:2], e[1:0]);
      end
    end
  endtask

  task automatic test_clean();
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      e = pop_exp();
      n_cmp++;
      if ({press_pulse, release_pulse, pressed} !== e) begin
        n_err++;
        $display("FAIL clean cyc=%0d got %b_%b_%b need %b_%b_%b", cyc, press_pulse, release_pulse, pressed, e[5:4], e[3:2], e[1:0]);
      end
      if (k == 0) begin key[0] = 1'b0; push(6, 2'b01, 2'b00); end
      if (k == 10) begin key[0] = 1'b1; push(6, 2'b00, 2'b01); end
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 34; k++) begin
      @(negedge clock);
      e = pop_exp();
      n_cmp++;
      if ({press_pulse, release_pulse, pressed} !== e) begin
        n_err++;
        $display("FAIL bounce cyc=%0d got %b_%b_%b need %b_%b_%b", cyc, press_pulse, release_pulse, pressed, e[5:4], e[3:2], e[1:0]);
      end
      if (k < 16) key[0] = ((k / 2) % 2) ? 1'b1 : 1'b0;
      if (k == 16) begin key[0] = 1'b0; push(6, 2'b01, 2'b00); end
      if (k == 26) begin key[0] = 1'b1; push(6, 2'b00, 2'b01); end
    end
  endtask

  task automatic test_window();
    for (int k = 0; k < 28; k++) begin
      @(negedge clock);
      e = pop_exp();
      n_cmp++;
      if ({press_pulse, release_pulse, pressed} !== e) begin
        n_err++;
        $display("FAIL window cyc=%0d got %b_%b_%b need %b_%b_%b", cyc, press_pulse, release_pulse, pressed, e[5:4], e[3:2], e[1:0]);
      end
      if (k == 0) key[1] = 1'b0;
      if (k == 3) key[1] = 1'b1;
      if (k == 10) begin key[1] = 1'b0; push(6, 2'b10, 2'b00); end
      if (k == 14) begin key[1] = 1'b1; push(6, 2'b00, 2'b10); end
    end
  endtask

  task automatic test_simul_reset();
    for (int k = 0; k < 44; k++) begin
      @(negedge clock);
      e = pop_exp();
      n_cmp++;
      if ({press_pulse, release_pulse, pressed} !== e) begin
        n_err++;
        $display("FAIL simul_reset cyc=%0d got %b_%b_%b need %b_%b_%b", cyc, press_pulse, release_pulse, pressed, e[5:4], e[3:2], e[1:0]);
      end
      if (k == 0) begin key = 2'b00; push(6, 2'b11, 2'b00); end
      if (k == 10) begin key = 2'b11; push(6, 2'b00, 2'b11); end
      if (k == 20) key = 2'b00;
      if (k == 23) do_reset();
      if (k == 24) begin reset_n = 1'b1; push(6, 2'b11, 2'b00); end
      if (k == 34) begin key = 2'b11; push(6, 2'b00, 2'b11); end
    end
  endtask

  task automatic test_held_reset();
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      e = pop_exp();
      n_cmp++;
      if ({press_pulse, release_pulse, pressed} !== e) begin
        n_err++;
        $display("FAIL held_reset cyc=%0d got %b_%b_%b need %b_%b_%b", cyc, press_pulse, release_pulse, pressed, e[5:4], e[3:2], e[1:0]);
      end
      if (k == 0) begin key[0] = 1'b0; push(6, 2'b01, 2'b00); end
      if (k == 10) do_reset();
      if (k == 13) begin reset_n = 1'b1; push(6, 2'b01, 2'b00); end
      if (k == 22) begin key = 2'b11; push(6, 2'b00, 2'b01); end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending need 0", sb.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    key = 2'b11;
    test_reset();
    test_clean();
    test_bounce();
    test_window();
    test_simul_reset();
    test_held_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
